// File: rtl/add_operand_sequencer_if.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | add_operand_sequencer_if : operand, adder and result bus of the sequencer |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
interface add_operand_sequencer_if #(
   parameter int DATA_W = 4
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_a;
   logic [DATA_W-1:0] in_b;
   logic [DATA_W-1:0] add_a;
   logic [DATA_W-1:0] add_b;
   logic [DATA_W:0]   add_sum;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W:0]   out_sum;
   logic              busy;

   modport slave (
      input  in_valid, in_a, in_b, add_sum, out_ready,
      output in_ready, add_a, add_b, out_valid, out_sum, busy
   );

   modport master (
      output in_valid, in_a, in_b, add_sum, out_ready,
      input  in_ready, add_a, add_b, out_valid, out_sum, busy
   );
endinterface
`default_nettype wire

// File: rtl/add_operand_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | add_operand_sequencer : FIFO-buffered operand feeder for a slow adder,    |
// | holding operands for a settle window before capturing the sum.            |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
module add_operand_sequencer #(
   parameter int DATA_W     = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int SETTLE_CYC = 2
) (
   input  wire                      clk,
   input  wire                      rst_n,
   add_operand_sequencer_if.slave   bus
);
   localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
   localparam int SCNT_W = $clog2(SETTLE_CYC + 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_HOLD   = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [SCNT_W-1:0]       cnt_q, cnt_d;
   logic [DATA_W-1:0]       add_a_q, add_a_d;
   logic [DATA_W-1:0]       add_b_q, add_b_d;
   logic [DATA_W:0]         out_sum_q, out_sum_d;
   logic                    out_valid_q, out_valid_d;

   logic [2*DATA_W-1:0]     mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]        count_q;

   logic                    w_in_ready;
   logic                    w_push;
   logic                    w_pop;
   logic                    w_fifo_nempty;
   logic [2*DATA_W-1:0]     w_head;

   // in_ready comes only from the registered count, so a full FIFO never
   // accepts in the same cycle it pops.
   assign w_in_ready    = rst_n && (count_q < CNT_W'(FIFO_DEPTH));
   assign w_push        = bus.in_valid && w_in_ready;
   assign w_fifo_nempty = (count_q != '0);
   assign w_head        = mem_q[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (w_push) begin
         mem_q[wr_ptr_q] <= {bus.in_a, bus.in_b};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (w_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (w_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         unique case ({w_push, w_pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         add_a_q     <= '0;
         add_b_q     <= '0;
         out_sum_q   <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         add_a_q     <= add_a_d;
         add_b_q     <= add_b_d;
         out_sum_q   <= out_sum_d;
         out_valid_q <= out_valid_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      add_a_d     = add_a_q;
      add_b_d     = add_b_q;
      out_sum_d   = out_sum_q;
      out_valid_d = out_valid_q;
      w_pop       = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (w_fifo_nempty) begin
               w_pop              = 1'b1;
               {add_a_d, add_b_d} = w_head;
               cnt_d              = SCNT_W'(SETTLE_CYC);
               state_d            = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            // The edge where cnt reads 1 is the last of the settle window.
            if (cnt_q == SCNT_W'(1)) begin
               out_sum_d   = bus.add_sum;
               out_valid_d = 1'b1;
               cnt_d       = '0;
               state_d     = ST_HOLD;
            end else begin
               cnt_d = cnt_q - SCNT_W'(1);
            end
         end
         ST_HOLD: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               if (w_fifo_nempty) begin
                  w_pop              = 1'b1;
                  {add_a_d, add_b_d} = w_head;
                  cnt_d              = SCNT_W'(SETTLE_CYC);
                  state_d            = ST_SETTLE;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.add_a     = add_a_q;
   assign bus.add_b     = add_b_q;
   assign bus.out_sum   = out_sum_q;
   assign bus.out_valid = out_valid_q;
   assign bus.busy      = (state_q != ST_IDLE) || w_fifo_nempty;
endmodule
`default_nettype wire

// File: tb/tb_add_operand_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_add_operand_sequencer : scoreboard bench for add_operand_sequencer     |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_add_operand_sequencer;
   localparam int DATA_W     = 4;
   localparam int FIFO_DEPTH = 4;
   localparam int SETTLE_CYC = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   add_operand_sequencer_if #(.DATA_W(DATA_W)) ifc ();
   add_operand_sequencer_if #(.DATA_W(DATA_W)) ifc1 ();

   add_operand_sequencer #(
      .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .SETTLE_CYC(SETTLE_CYC)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(ifc)
   );

   add_operand_sequencer #(
      .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .SETTLE_CYC(1)
   ) dut1 (
      .clk(clk), .rst_n(rst_n), .bus(ifc1)
   );

   // Slow combinational adders sitting downstream of each sequencer
   always @(ifc.add_a or ifc.add_b)
      #5 ifc.add_sum = {1'b0, ifc.add_a} + {1'b0, ifc.add_b};
   always @(ifc1.add_a or ifc1.add_b)
      #5 ifc1.add_sum = {1'b0, ifc1.add_a} + {1'b0, ifc1.add_b};

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int n_out = 0;
   logic [DATA_W:0] exp_q [$];
   int              xfer_q [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard / protocol monitor, sampling mid-cycle
   logic [DATA_W-1:0] prev_a, prev_b;
   logic [DATA_W:0]   prev_sum;
   logic              prev_valid;
   int                stable_cnt;
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         prev_a     = '0;
         prev_b     = '0;
         prev_sum   = '0;
         prev_valid = 1'b0;
         stable_cnt = 0;
      end else begin
         if (ifc.in_valid && ifc.in_ready)
            exp_q.push_back({1'b0, ifc.in_a} + {1'b0, ifc.in_b});
         if (ifc.add_a !== prev_a || ifc.add_b !== prev_b) stable_cnt = 0;
         else stable_cnt++;
         if (ifc.out_valid && !prev_valid) begin
            chk("settle_window", stable_cnt, SETTLE_CYC);
            chk("sum_vs_operands", ifc.out_sum, {1'b0, ifc.add_a} + {1'b0, ifc.add_b});
         end
         if (ifc.out_valid && prev_valid)
            chk("hold_frozen", {ifc.add_a, ifc.add_b, ifc.out_sum}, {prev_a, prev_b, prev_sum});
         if (ifc.out_valid && ifc.out_ready) begin
            n_out++;
            xfer_q.push_back(cyc);
            if (exp_q.size() == 0) chk("unexpected_out", ifc.out_sum, 'hDEAD);
            else chk("scoreboard", ifc.out_sum, exp_q.pop_front());
         end
         prev_a     = ifc.add_a;
         prev_b     = ifc.add_b;
         prev_sum   = ifc.out_sum;
         prev_valid = ifc.out_valid;
      end
   end

   // All tasks start and end at posedge+1
   task automatic push(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b, input string tag);
      int w = 0;
      ifc.in_valid = 1'b1;
      ifc.in_a     = a;
      ifc.in_b     = b;
      while (ifc.in_ready !== 1'b1 && w < 100) begin
         @(posedge clk); #1; w++;
      end
      if (ifc.in_ready !== 1'b1) chk({tag, "_push_timeout"}, 0, 1);
      @(posedge clk); #1;
      ifc.in_valid = 1'b0;
   endtask

   task automatic wait_valid(input string tag, output int n);
      n = 0;
      while (ifc.out_valid !== 1'b1 && n < 50) begin
         @(posedge clk); #1; n++;
      end
      if (ifc.out_valid !== 1'b1) chk({tag, "_valid_timeout"}, 0, 1);
   endtask

   task automatic wait_drain(input string tag);
      int w = 0;
      while ((exp_q.size() != 0 || ifc.busy !== 1'b0 || ifc.out_valid !== 1'b0) && w < 200) begin
         @(posedge clk); #1; w++;
      end
      chk({tag, "_drained"}, (exp_q.size() == 0 && ifc.busy === 1'b0), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int base;
      ifc.in_valid   = 1'b0; ifc.in_a  = '0; ifc.in_b  = '0; ifc.out_ready  = 1'b1;
      ifc1.in_valid  = 1'b0; ifc1.in_a = '0; ifc1.in_b = '0; ifc1.out_ready = 1'b1;

      // Reset state
      #1 rst_n = 1'b0;
      #1;
      chk("rst_in_ready", ifc.in_ready, 0);
      chk("rst_out_valid", ifc.out_valid, 0);
      chk("rst_add_ab", {ifc.add_a, ifc.add_b}, 0);
      chk("rst_out_sum", ifc.out_sum, 0);
      chk("rst_busy", ifc.busy, 0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_in_ready", ifc.in_ready, 1);

      // 1: basic sum and push-to-valid latency
      push(4'hA, 4'h3, "t1");
      wait_valid("t1", n);
      chk("t1_latency", n, SETTLE_CYC + 1);
      chk("t1_sum", ifc.out_sum, 5'h0D);
      wait_drain("t1");

      // 2: carry out, then a plain sum
      push(4'hF, 4'hF, "t2a");
      wait_valid("t2a", n);
      chk("t2a_sum", ifc.out_sum, 5'h1E);
      wait_drain("t2a");
      push(4'h2, 4'h8, "t2b");
      wait_valid("t2b", n);
      chk("t2b_sum", ifc.out_sum, 5'h0A);
      wait_drain("t2b");

      // 3: backpressure, FIFO fills, nothing lost
      base = n_out;
      ifc.out_ready = 1'b0;
      push(4'h1, 4'h9, "t3");
      push(4'h2, 4'h7, "t3");
      push(4'h3, 4'h6, "t3");
      push(4'h4, 4'h5, "t3");
      push(4'h5, 4'h4, "t3");
      ifc.in_valid = 1'b1; ifc.in_a = 4'h6; ifc.in_b = 4'h3;
      repeat (4) begin
         chk("t3_full_in_ready", ifc.in_ready, 0);
         @(posedge clk); #1;
      end
      chk("t3_frozen_add", {ifc.add_a, ifc.add_b}, {4'h1, 4'h9});
      chk("t3_frozen_sum", ifc.out_sum, 5'h0A);
      chk("t3_held_valid", ifc.out_valid, 1);
      ifc.out_ready = 1'b1;
      push(4'h6, 4'h3, "t3");
      wait_drain("t3");
      chk("t3_result_count", n_out - base, 6);

      // 4: streaming throughput
      xfer_q.delete();
      push(4'h1, 4'h1, "t4");
      push(4'h2, 4'h2, "t4");
      push(4'h3, 4'h3, "t4");
      wait_drain("t4");
      chk("t4_count", xfer_q.size(), 3);
      if (xfer_q.size() == 3) begin
         chk("t4_spacing0", xfer_q[1] - xfer_q[0], SETTLE_CYC + 1);
         chk("t4_spacing1", xfer_q[2] - xfer_q[1], SETTLE_CYC + 1);
      end

      // 5: reset mid-settle with entries queued
      push(4'h1, 4'h2, "t5");
      push(4'h3, 4'h4, "t5");
      push(4'h5, 4'h6, "t5");
      chk("t5_pre_add_a", ifc.add_a, 4'h1);
      chk("t5_pre_busy", ifc.busy, 1);
      rst_n = 1'b0;
      #1;
      chk("t5_rst_out_valid", ifc.out_valid, 0);
      chk("t5_rst_add_ab", {ifc.add_a, ifc.add_b}, 0);
      chk("t5_rst_busy", ifc.busy, 0);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      n = 0;
      repeat (8) begin
         @(posedge clk); #1;
         if (ifc.out_valid !== 1'b0) n++;
      end
      chk("t5_no_stale", n, 0);
      chk("t5_idle_busy", ifc.busy, 0);
      push(4'h4, 4'h5, "t5");
      wait_valid("t5", n);
      chk("t5_sum", ifc.out_sum, 5'h09);
      wait_drain("t5");

      // 6: single-cycle settle instance
      chk("t6_in_ready", ifc1.in_ready, 1);
      ifc1.in_valid = 1'b1; ifc1.in_a = 4'h7; ifc1.in_b = 4'h9;
      @(posedge clk); #1;
      ifc1.in_valid = 1'b0;
      @(posedge clk); #1;
      chk("t6_pop_add", {ifc1.add_a, ifc1.add_b}, {4'h7, 4'h9});
      chk("t6_not_yet", ifc1.out_valid, 0);
      @(posedge clk); #1;
      chk("t6_valid", ifc1.out_valid, 1);
      chk("t6_sum", ifc1.out_sum, 5'h10);
      @(posedge clk); #1;
      chk("t6_done", ifc1.busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
